// File: rtl/snn_bus_pkg.sv
// snn_bus_pkg: shared state type and address-field constants for the SNN bus bridge
package snn_bus_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, CALC_WAIT, RESP} bridge_state_t;
  localparam int CORE_BIT = 16;
  localparam int REGION_LSB = 17;
  localparam int CALC_LSB = 20;
  localparam logic [1:0] REGION_SPIKE_IN = 2'b00;
  localparam logic [1:0] REGION_PARAM_IN = 2'b01;
  localparam logic [1:0] REGION_SPIKE_OUT = 2'b10;
  localparam logic [1:0] REGION_RSVD = 2'b11;
endpackage

// File: rtl/snn_bus_bridge.sv
// snn_bus_bridge: single-outstanding bus slave driving decoder address, core strobes and calc sequencing
module snn_bus_bridge
  import snn_bus_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int CALC_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] addr_o,
  output logic        wr_en_o,
  output logic        rd_en_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  calc_done_i
);
  bridge_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] addr_n, wdata_n, rdata_n;
  logic wr_n, rd_n, valid_n, err_n;
  logic [1:0] req_calc, req_region, mask;
  assign req_ready_o = state == IDLE;
  assign req_calc = req_addr_i[CALC_LSB +: 2];
  assign req_region = req_addr_i[REGION_LSB +: 2];
  assign mask = addr_o[CALC_LSB +: 2];
  always_comb begin
    state_n = state;
    cnt_n = &cnt ? cnt : cnt + 16'd1;
    addr_n = addr_o;
    wdata_n = wdata_o;
    rdata_n = rsp_rdata_o;
    wr_n = 1'b0;
    rd_n = 1'b0;
    valid_n = rsp_valid_o;
    err_n = rsp_err_o;
    case (state)
      IDLE: if (req_valid_i) begin
        cnt_n = '0;
        addr_n = req_addr_i;
        wdata_n = req_wdata_i;
        rdata_n = '0;
        if (req_calc != 2'b00) state_n = CALC_WAIT;
        else if (req_region == REGION_RSVD || (req_we_i && req_region == REGION_SPIKE_OUT)) begin
          state_n = RESP;
          addr_n = '0;
          valid_n = 1'b1;
          err_n = 1'b1;
        end else if (req_we_i) begin
          state_n = WRITE;
          wr_n = 1'b1;
        end else begin
          state_n = READ_WAIT;
          rd_n = 1'b1;
        end
      end
      WRITE: begin
        state_n = RESP;
        addr_n = '0;
        valid_n = 1'b1;
      end
      READ_WAIT: if (cnt == 16'(READ_LATENCY)) begin
        state_n = RESP;
        addr_n = '0;
        rdata_n = rdata_i;
        valid_n = 1'b1;
      end
      CALC_WAIT: if ((calc_done_i & mask) == mask) begin
        state_n = RESP;
        addr_n = '0;
        valid_n = 1'b1;
      end else if (CALC_TIMEOUT != 0 && cnt >= 16'(CALC_TIMEOUT - 1)) begin
        state_n = RESP;
        addr_n = '0;
        valid_n = 1'b1;
        err_n = 1'b1;
      end
      RESP: if (rsp_ready_i) begin
        state_n = IDLE;
        valid_n = 1'b0;
        err_n = 1'b0;
        rdata_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      addr_o <= '0;
      wdata_o <= '0;
      rsp_rdata_o <= '0;
      wr_en_o <= 1'b0;
      rd_en_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr_o <= addr_n;
      wdata_o <= wdata_n;
      rsp_rdata_o <= rdata_n;
      wr_en_o <= wr_n;
      rd_en_o <= rd_n;
      rsp_valid_o <= valid_n;
      rsp_err_o <= err_n;
    end
  end
endmodule

// File: tb/tb_snn_bus_bridge.sv
// tb_snn_bus_bridge: cycle-level checks of two bridge instances against a request-latency model
module tb_snn_bus_bridge;
  localparam int RL = 2;
  localparam int TO0 = 1024;
  localparam int TO1 = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid [2], req_ready [2], req_we [2], rsp_valid [2], rsp_ready [2], rsp_err [2], wr_en [2], rd_en [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2], addr [2], wdata [2], rdata [2];
  logic [1:0] calc_done [2];
  logic e_ready [2], e_valid [2], e_err [2], e_wr [2], e_rd [2];
  logic [31:0] e_addr [2], e_wdata [2], e_rdata [2], last_wd [2];
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  snn_bus_bridge #(.READ_LATENCY(RL), .CALC_TIMEOUT(TO0)) u0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .addr_o(addr[0]), .wr_en_o(wr_en[0]), .rd_en_o(rd_en[0]),
    .wdata_o(wdata[0]), .rdata_i(rdata[0]), .calc_done_i(calc_done[0])
  );
  snn_bus_bridge #(.READ_LATENCY(RL), .CALC_TIMEOUT(TO1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .addr_o(addr[1]), .wr_en_o(wr_en[1]), .rd_en_o(rd_en[1]),
    .wdata_o(wdata[1]), .rdata_i(rdata[1]), .calc_done_i(calc_done[1])
  );
  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_on) for (int k = 0; k < 2; k++) begin
    chk(k, "req_ready", {31'd0, req_ready[k]}, {31'd0, e_ready[k]});
    chk(k, "rsp_valid", {31'd0, rsp_valid[k]}, {31'd0, e_valid[k]});
    chk(k, "rsp_err", {31'd0, rsp_err[k]}, {31'd0, e_err[k]});
    chk(k, "wr_en", {31'd0, wr_en[k]}, {31'd0, e_wr[k]});
    chk(k, "rd_en", {31'd0, rd_en[k]}, {31'd0, e_rd[k]});
    chk(k, "addr", addr[k], e_addr[k]);
    chk(k, "wdata", wdata[k], e_wdata[k]);
    chk(k, "rsp_rdata", rsp_rdata[k], e_rdata[k]);
  end
  function automatic logic [1:0] done_at(input int c, input logic [1:0] v1, input int d1, input logic [1:0] v2, input int d2);
    return c >= d2 ? v2 : c >= d1 ? v1 : 2'b00;
  endfunction
  function automatic void model(input int k, input bit we, input logic [31:0] a, input logic [1:0] v1, input int d1,
                                input logic [1:0] v2, input int d2, output int r, output bit err, output int kind);
    logic [1:0] m, rg, dn;
    int to;
    m = a[21:20];
    rg = a[18:17];
    to = k == 0 ? TO0 : TO1;
    err = 1'b0;
    r = 0;
    if (m != 2'b00) begin
      kind = 3;
      for (int c = 1; c <= 2000 && r == 0; c++) begin
        dn = done_at(c, v1, d1, v2, d2);
        if ((dn & m) == m) r = c + 1;
        else if (to != 0 && c == to) begin
          r = c + 1;
          err = 1'b1;
        end
      end
    end else if (rg == 2'b11 || (we && rg == 2'b10)) begin
      kind = 2;
      r = 1;
      err = 1'b1;
    end else if (we) begin
      kind = 0;
      r = 2;
    end else begin
      kind = 1;
      r = RL + 2;
    end
  endfunction
  task automatic set_idle(input int j);
    req_valid[j] = 1'b0;
    req_we[j] = 1'b0;
    req_addr[j] = '0;
    req_wdata[j] = '0;
    rsp_ready[j] = 1'b0;
    rdata[j] = '0;
    calc_done[j] = 2'b00;
    e_ready[j] = 1'b1;
    e_valid[j] = 1'b0;
    e_err[j] = 1'b0;
    e_wr[j] = 1'b0;
    e_rd[j] = 1'b0;
    e_addr[j] = '0;
    e_rdata[j] = '0;
    e_wdata[j] = last_wd[j];
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle(0);
      set_idle(1);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic txn(input int k, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rv,
                     input logic [1:0] v1, input int d1, input logic [1:0] v2, input int d2, input int bp, input int lit_r);
    int r, kind, obs;
    bit err;
    model(k, we, a, v1, d1, v2, d2, r, err, kind);
    chk(k, "model_rsp_cycle", r, lit_r);
    obs = -1;
    set_idle(1 - k);
    for (int c = 0; c <= r + bp; c++) begin
      req_valid[k] = c == 0;
      req_we[k] = c == 0 ? we : 1'($urandom);
      req_addr[k] = c == 0 ? a : $urandom;
      req_wdata[k] = c == 0 ? wd : $urandom;
      rdata[k] = (kind == 1 && c == RL + 1) ? rv : $urandom;
      rsp_ready[k] = bp == 0 || c >= r + bp;
      calc_done[k] = c == 0 ? 2'b00 : done_at(c, v1, d1, v2, d2);
      e_ready[k] = c == 0;
      e_valid[k] = c >= r;
      e_err[k] = c >= r && err;
      e_rdata[k] = (c >= r && kind == 1) ? rv : 32'd0;
      e_wr[k] = kind == 0 && c == 1;
      e_rd[k] = kind == 1 && c == 1;
      e_addr[k] = (c >= 1 && c < r) ? a : 32'd0;
      e_wdata[k] = c >= 1 ? wd : last_wd[k];
      @(negedge clk);
      if (obs < 0 && rsp_valid[k]) obs = c;
      @(posedge clk);
      #1;
    end
    last_wd[k] = wd;
    chk(k, "dut_rsp_cycle", obs, lit_r);
  endtask
  task automatic mid_reset();
    logic [31:0] a = 32'h0002_0000;
    logic [31:0] wd = 32'h5555_AAAA;
    set_idle(0);
    set_idle(1);
    req_valid[0] = 1'b1;
    req_addr[0] = a;
    req_wdata[0] = wd;
    @(posedge clk);
    #1;
    set_idle(0);
    e_ready[0] = 1'b0;
    e_rd[0] = 1'b1;
    e_addr[0] = a;
    e_wdata[0] = wd;
    @(posedge clk);
    #1;
    e_rd[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_wd[0] = '0;
    last_wd[1] = '0;
    idle(6);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      last_wd[k] = '0;
      set_idle(k);
    end
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    txn(0, 1'b1, 32'h0003_0000, 32'hDEAD_BEEF, 32'h0, 2'b00, 99, 2'b00, 99, 0, 2);
    txn(0, 1'b0, 32'h0004_0000, 32'h1111_2222, 32'h0000_00A5, 2'b00, 99, 2'b00, 99, 0, 4);
    txn(0, 1'b1, 32'h0004_0000, 32'h3333_4444, 32'h0, 2'b00, 99, 2'b00, 99, 0, 1);
    txn(0, 1'b0, 32'h0006_0000, 32'h0, 32'h0000_0077, 2'b00, 99, 2'b00, 99, 0, 1);
    idle(2);
    txn(0, 1'b0, 32'h0030_0000, 32'h0, 32'h0, 2'b01, 5, 2'b11, 9, 0, 10);
    txn(1, 1'b0, 32'h0010_0000, 32'h0, 32'h0, 2'b00, 99, 2'b00, 99, 0, 9);
    txn(0, 1'b0, 32'h0001_0004, 32'h0, 32'h1234_5678, 2'b00, 99, 2'b00, 99, 5, 4);
    txn(1, 1'b1, 32'h0020_0000, 32'hCAFE_F00D, 32'h0, 2'b01, 1, 2'b11, 3, 0, 4);
    txn(0, 1'b0, 32'h0010_0000, 32'h0, 32'h0, 2'b01, 1, 2'b01, 99, 0, 2);
    txn(1, 1'b1, 32'h0000_0010, 32'h0BAD_CAFE, 32'h0, 2'b00, 99, 2'b00, 99, 2, 2);
    txn(1, 1'b0, 32'h0005_0008, 32'h0, 32'hFFFF_0001, 2'b00, 99, 2'b00, 99, 0, 4);
    idle(2);
    mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
